uart_state_reporter: RTL and testbench
======================================

# uart_state_reporter

Telemetry transmitter for the FPGA build of the mimosa design. It sits downstream of the `moody_mimosa` core in the board top level. It snapshots the core's 8-bit output state on request and streams it to the host over the board's `usb_tx` pin as a 4-byte ASCII frame: two uppercase hex digits followed by CR LF. This lets the model's behaviour be logged from a terminal without a logic analyser.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
- `clk`  input  1  main clock; all logic in this single domain.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `state_in`  input  8  value to report; connected to the core's `uo_out`.
- `trigger`  input  1  single-cycle request pulse, typically the rising edge of the prescaled model clock.
- `tx`  output  1  UART line, 8N1, LSB first, idle high.
- `busy`  output  1  high while a frame is being transmitted.
- `overrun`  output  1  single-cycle pulse when a request is dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `overrun`=0, FSM=IDLE, pending=0, all counters 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE→START when a request is present. A request is `trigger`, or pending=1.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→STOP after 8 bits.
  - STOP→START for next byte if byte index < 3.
  - STOP→IDLE after byte 3.
- Snapshot: `state_in` is latched into a snapshot register on the cycle the frame is accepted. Later changes to `state_in` do not alter the frame in flight.
- Frame bytes in order:
  - ASCII hex of snapshot[7:4].
  - ASCII hex of snapshot[3:0].
  - 0x0D.
  - 0x0A.
- Hex mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46.
- Request while `busy`: sets the one-deep pending flag.
  - A further request while pending is already set is dropped and pulses `overrun` for one cycle.
  - Pending frame starts immediately after the last stop bit. It snapshots `state_in` at that cycle.
- `trigger` in the same cycle a frame ends (last stop-bit cycle) sets pending; it is not an overrun.

## Timing
- `trigger` sampled high at edge N: snapshot latched at N, `tx` falls and `busy` rises at edge N+1.
- Bit period is exactly CLKS_PER_BIT cycles. Bytes are back-to-back with no idle gap between stop bit and next start bit.
- Frame length is 40·CLKS_PER_BIT cycles. `busy` falls on the edge that ends the fourth stop bit.
- Pending frame: its start bit begins on the cycle immediately after the previous frame's final stop bit; `busy` stays high throughout.
- `rst_n` asserted mid-frame: `tx` goes to 1 and `busy` to 0 asynchronously. Pending is cleared. The partial frame is abandoned, not resumed.

## Configuration
- `REPORTER_ON_CHANGE_EN` defined:
  - An extra 8-bit last-reported register (reset 0) is compiled in.
  - In IDLE, `state_in` ≠ last-reported generates an internal request identical to `trigger`.
  - Last-reported updates on every snapshot.
- Macro undefined: frames are sent only on `trigger`/pending; the register and comparator are absent.

## Structure
- Shared package `uart_reporter_pkg` holds:
  - The FSM state enum.
  - ASCII constants for CR and LF.
  - Frame length constant (4).
  - `hex_to_ascii` function (4-bit → 8-bit).
- One sub-module, `uart_tx_byte`: byte serializer with baud counter and valid/ready handshake. `uart_state_reporter` owns framing, snapshot, pending and overrun.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Single frame: `state_in`=0x3A, `trigger` pulse at N. Required response:
  - `tx` decodes 0x33, 0x41, 0x0D, 0x0A.
  - `busy` is high for edges N+1..N+160.
  - `tx`=1 afterward.
- Snapshot hold: `state_in`=0x00 at trigger, changed to 0xFF mid-frame. Required response: frame reads "00\r\n".
- Pending and overrun:
  - Stimulus: three triggers during one frame with `state_in`=0x5C at frame end.
  - Required response: exactly one `overrun` pulse, at the third trigger. The second frame "5C\r\n" starts with zero idle cycles.
- Reset mid-frame: `rst_n` low during byte 2. Required response:
  - `tx`=1 and `busy`=0 with no clock edge.
  - After release, no frame is sent until the next trigger.
- With `REPORTER_ON_CHANGE_EN`, no trigger: `state_in` steps 0x00→0x07. Required response: one frame "07\r\n"; holding 0x07 produces no further frames.
- Without `REPORTER_ON_CHANGE_EN`, the same stimulus: `tx` stays 1 throughout.

Source files
------------

// File: rtl/uart_reporter_pkg.sv
// Shared types and constants for the UART state reporter: serializer FSM
// states, frame byte constants and the nibble-to-ASCII helper.
package uart_reporter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  localparam logic [7:0]  ASCII_CR  = 8'h0D;
  localparam logic [7:0]  ASCII_LF  = 8'h0A;
  localparam int unsigned FRAME_LEN = 4;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'b0000, nib};
    else             return 8'h37 + {4'b0000, nib};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with baud counter; accepts a byte on valid & ready.
// Ready is also raised in the last stop-bit cycle so bytes can run back-to-back.
module uart_tx_byte
  import uart_reporter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (cnt_q == BIT_LAST);
  assign ready   = (state_q == S_IDLE) || ((state_q == S_STOP) && bit_end);
  assign tx      = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d = S_START;
          cnt_d   = '0;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (valid) begin
            state_d = S_START;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_state_reporter.sv
// Snapshots state_in on request and sends it as "HH\r\n" over UART.
// Optional REPORTER_ON_CHANGE_EN: also request a frame when idle and state_in differs from the last report.
module uart_state_reporter
  import uart_reporter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] state_in,
  input  logic       trigger,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN);

  logic       active_q, active_d;
  logic       busy_q, busy_d;
  logic       pending_q, pending_d;
  logic       overrun_q, overrun_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] snap_q, snap_d;
  logic       take_snap, frame_end, change_req;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;

`ifdef REPORTER_ON_CHANGE_EN
  logic [7:0] last_q;
  assign change_req = (state_in != last_q);
`else
  assign change_req = 1'b0;
`endif

  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [7:0] v);
    case (idx)
      2'd0:    return hex_to_ascii(v[7:4]);
      2'd1:    return hex_to_ascii(v[3:0]);
      2'd2:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  always_comb begin
    active_d  = active_q;
    busy_d    = busy_q;
    pending_d = pending_q;
    overrun_d = 1'b0;
    idx_d     = idx_q;
    snap_d    = snap_q;
    take_snap = 1'b0;
    tx_valid  = active_q && (idx_q != LAST_IDX);
    tx_data   = frame_byte(idx_q[1:0], snap_q);
    frame_end = active_q && (idx_q == LAST_IDX) && tx_ready;

    if (!active_q) begin
      if (trigger || pending_q || change_req) begin
        active_d  = 1'b1;
        take_snap = 1'b1;
        idx_d     = '0;
        pending_d = 1'b0;
      end
    end else if (frame_end) begin
      // A pending frame is chained into the final stop-bit cycle: its first
      // byte comes straight from state_in, which is snapshotted on the same edge.
      busy_d    = pending_q;
      active_d  = pending_q;
      pending_d = trigger;
      if (pending_q) begin
        take_snap = 1'b1;
        idx_d     = 3'd1;
        tx_valid  = 1'b1;
        tx_data   = hex_to_ascii(state_in[7:4]);
      end
    end else begin
      if (tx_valid && tx_ready) begin
        idx_d = idx_q + 3'd1;
        if (idx_q == '0) busy_d = 1'b1;
      end
      if (trigger) begin
        if (pending_q) overrun_d = 1'b1;
        else           pending_d = 1'b1;
      end
    end

    if (take_snap) snap_d = state_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= '0;
      snap_q    <= '0;
`ifdef REPORTER_ON_CHANGE_EN
      last_q    <= '0;
`endif
    end else begin
      active_q  <= active_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
`ifdef REPORTER_ON_CHANGE_EN
      if (take_snap) last_q <= state_in;
`endif
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(tx_valid),
    .data (tx_data),
    .ready(tx_ready),
    .tx   (tx)
  );

  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_state_reporter.sv
// Scoreboard bench for uart_state_reporter: stimulus pushes expected frame bytes,
// a UART line decoder pops and compares them; timing checks run alongside.
module tb_uart_state_reporter;

  localparam int unsigned CPB       = 4;
  localparam int          FRAME_CYC = 40 * CPB;
`ifdef REPORTER_ON_CHANGE_EN
  localparam int ONCHG_BYTES = 4;
`else
  localparam int ONCHG_BYTES = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger;
  logic [7:0] state_in;
  logic       tx, busy, overrun;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         ov_count = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  uart_state_reporter #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_in(state_in),
    .trigger (trigger),
    .tx      (tx),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (overrun === 1'b1) ov_count <= ov_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: one frame is two uppercase hex characters, CR, LF.
  function automatic logic [7:0] hex_char(input int d);
    return (d < 10) ? 8'(48 + d) : 8'(55 + d);
  endfunction

  task automatic push_frame(input logic [7:0] v);
    exp_q.push_back(hex_char(int'(v) / 16));
    exp_q.push_back(hex_char(int'(v) % 16));
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd10);
  endtask

  // UART receiver: samples mid-bit on falling clock edges; abandons a byte if reset is seen.
  initial begin : rx_decoder
    logic [7:0] b;
    logic       stop_bit;
    logic       aborted;
    int         st;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        st      = cyc;
        aborted = 1'b0;
        b       = '0;
        repeat (CPB / 2) @(negedge clk);
        if (rst_n !== 1'b1 || tx !== 1'b0) aborted = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (rst_n !== 1'b1) aborted = 1'b1;
        stop_bit = tx;
        if (!aborted) begin
          starts.push_back(st);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_unexpected: got byte 0x%02h, expected none (cycle %0d)", b, cyc);
          end else begin
            check("rx_byte", b, exp_q.pop_front());
          end
          check("rx_stop", stop_bit, 1);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now("drain_timeout");
  endtask

  task automatic single_frame(input logic [7:0] v, input logic [7:0] alt);
    int n0, base;
    base = starts.size();
    @(negedge clk);
    state_in = v;
    trigger  = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    push_frame(v);
    n0 = cyc;
    check("busy_before", busy, 0);
    check("tx_before", tx, 1);
    for (int k = 1; k <= FRAME_CYC + 1; k++) begin
      @(negedge clk);
      if (k == 60)  state_in = alt;
      if (k == 150) state_in = v;
      check("busy_window", busy, (k <= FRAME_CYC) ? 1 : 0);
      if (k == 1) check("tx_start", tx, 0);
    end
    check("tx_after", tx, 1);
    wait_idle(50);
    if (starts.size() > base) check("frame_start_cycle", starts[base], n0 + 1);
    else fail_now("frame_start_missing");
  endtask

  task automatic pending_test();
    logic [7:0] v;
    int n0, base, ov0;
    v    = 8'($urandom_range(0, 255));
    base = starts.size();
    ov0  = ov_count;
    @(negedge clk);
    state_in = v;
    trigger  = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    push_frame(v);
    n0 = cyc;
    for (int k = 1; k <= 2 * FRAME_CYC + 1; k++) begin
      @(negedge clk);
      if (k == 20 || k == 60) trigger = 1'b1;
      if (k == 21) begin
        trigger = 1'b0;
        push_frame(8'h5C);
      end
      if (k == 61) begin
        trigger = 1'b0;
        check("overrun_pulse", overrun, 1);
      end
      if (k == 62) check("overrun_clear", overrun, 0);
      if (k == 100) state_in = 8'h5C;
      check("busy_chained", busy, (k <= 2 * FRAME_CYC) ? 1 : 0);
    end
    wait_idle(50);
    check("overrun_count", ov_count - ov0, 1);
    if (starts.size() >= base + 5) begin
      check("first_start", starts[base], n0 + 1);
      check("chained_start", starts[base + 4], n0 + 1 + FRAME_CYC);
    end else begin
      fail_now("chained_frame_missing");
    end
  endtask

  task automatic reset_test();
    logic [7:0] v;
    int base;
    v = 8'($urandom_range(0, 255));
    @(negedge clk);
    state_in = v;
    trigger  = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    push_frame(v);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    exp_q.delete();
    state_in = 8'h00;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    base  = starts.size();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("idle_after_rst", tx, 1);
    end
    check("busy_after_rst", busy, 0);
    check("no_frame_after_rst", starts.size() - base, 0);
    v = 8'($urandom_range(0, 255));
    single_frame(v, v);
  endtask

  task automatic onchange_test();
    int base;
    @(negedge clk);
    rst_n    = 1'b0;
    state_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    base = starts.size();
    state_in = 8'h07;
`ifdef REPORTER_ON_CHANGE_EN
    push_frame(8'h07);
`endif
    for (int k = 0; k < 2 * FRAME_CYC + 100; k++) begin
      @(negedge clk);
`ifndef REPORTER_ON_CHANGE_EN
      check("tx_idle_no_trigger", tx, 1);
`endif
    end
    wait_idle(50);
    check("onchange_bytes", starts.size() - base, ONCHG_BYTES);
  endtask

  initial begin
    logic [7:0] v;
    rst_n    = 1'b1;
    trigger  = 1'b0;
    state_in = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    single_frame(8'h3A, 8'hC5);
    single_frame(8'h00, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 15)) @(negedge clk);
      single_frame(v, ~v);
    end
    pending_test();
    reset_test();
    onchange_test();

    check("overrun_total", ov_count, 1);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
